lvds_status_multi: RTL and testbench
====================================

// Module: lvds_status_multi
// PURPOSE
//  Parametrised multi-channel LVDS clock-health monitor in the clk_fpga (100 MHz) domain.
//  Each channel clk_in[i] (nominal 1 MHz) is synchronised, both half-periods are measured
//  and checked against a [MIN_HALF..MAX_HALF] window, and the channel is also watchdogged.
//  Gives per-channel qualified status plus an AND-ed global status for the check unit.
// PARAMETERS
//  N_CH           4    number of monitored LVDS clock channels (1..16)
//  CNT_W          8    half-period / watchdog counter width, in bits
//  MIN_HALF       44   minimum legal half-period, in clk_fpga cycles (inclusive)
//  MAX_HALF       56   maximum legal half-period, in clk_fpga cycles (inclusive)
//  WATCHDOG_TIME  150  number of cycles with no edge before the channel is declared dead
//  GOOD_CNT       4    consecutive legal half-periods required before status asserts
// PORTS
//  clk_fpga     in   1     system clock, 100 MHz
//  rst          in   1     synchronous reset, active-high
//  clk_in       in   N_CH  asynchronous monitored LVDS clocks
//  ch_status    out  N_CH  per-channel qualified-good flag
//  status       out  1     global status: AND of all ch_status bits, registered
//  fault_sticky out  N_CH  sticky loss flags (present only with LVDS_STATUS_STICKY_EN)
//  fault_clr    in   N_CH  per-channel sticky clear pulses (present only with the macro)
// BEHAVIOUR
//  - Reset: every output is 0. All counters are 0. Each channel sets seen_edge=0 and good=0.
//  - Synchroniser: clk_in -> s_meta -> s_sync -> s_prev, each stage a flop.
//    edge = s_sync ^ s_prev. Latency from a pin transition to the edge cycle is 2 cycles.
//  - Half-period counter hp: on an edge cycle hp <= 1. Otherwise hp <= hp+1, saturating
//    at 2^CNT_W-1. On an edge cycle, hp equals W, the number of cycles the old level held.
//  - Check on edge: legal = (MIN_HALF <= W <= MAX_HALF). The level that ended is s_prev.
//    The same rule applies to both levels.
//  - The first edge after reset or after watchdog expiry only sets seen_edge=1; no check runs.
//  - Qualification counter good: +1 on each legal edge, saturating at GOOD_CNT. Cleared to 0
//    on an illegal edge or on watchdog expiry.
//  - Watchdog wd: cleared to 0 on an edge, otherwise +1. On reaching WATCHDOG_TIME it holds,
//    and dead=1 plus seen_edge=0. The next edge clears dead.
//  - ch_status[i] <= (good==GOOD_CNT) & ~dead. It is registered, so it updates 1 cycle after
//    the deciding edge or expiry. It drops at once on a single illegal half-period.
//  - status <= &ch_status, one further cycle.
//  - Edge and watchdog expiry in the same cycle: the edge wins (wd cleared, no expiry).
//  - Reset mid-operation returns to the reset state next cycle. No partial measurement is kept.
//  - Channels are fully independent; no shared state other than status.
// CONFIGURATION
//  LVDS_STATUS_STICKY_EN defined:
//    - fault_sticky/fault_clr exist.
//    - fault_sticky[i] sets the cycle after ch_status[i] falls 1->0.
//    - It holds until a fault_clr[i] cycle; a same-cycle set beats the clear.
//  Not defined: ports are absent; no sticky logic is generated.
// STRUCTURE
//  - Package lvds_status_pkg holds the default constants (MIN_HALF, MAX_HALF, WATCHDOG_TIME,
//    GOOD_CNT) and typedef ch_state_t {seen_edge, dead, good, hp, wd}.
//  - Sub-module lvds_status_ch: synchroniser, counters and ch_status for one channel.
//    It is instantiated N_CH times in a generate loop. The top holds the global AND and the
//    optional sticky register.
//  - Elaboration checks: MIN_HALF <= MAX_HALF < WATCHDOG_TIME < 2^CNT_W, and GOOD_CNT >= 1.
// TESTING
//  - 50/50 1 MHz on ch0:
//    -> ch_status[0] rises 1 cycle after the 5th edge (first edge plus 4 legal edges).
//    -> status rises once all channels are qualified.
//  - Duty 40/60 cycles:
//    -> the 40-cycle half is illegal; ch_status stays 0 and never qualifies.
//  - Good clock, then clk_in held:
//    -> ch_status falls 1 cycle after wd hits 150.
//    -> After restart, 5 edges re-qualify the channel.
//  - Boundary widths 44/56 are accepted; 43/57 drop ch_status the cycle after that edge.
//  - Qualified channels with rst pulsed for 1 cycle:
//    -> all outputs are 0 next cycle; re-qualification needs 5 edges.
//  - STICKY_EN: drop ch2 -> fault_sticky[2]=1 until fault_clr[2].
//    A clear in the same cycle as a new fault keeps it at 1; the other channels are unaffected.

Source files
------------

// File: rtl/lvds_status_pkg.sv
// lvds_status_pkg: default constants and the per-channel state record shared by
// the multi-channel LVDS clock-health monitor (lvds_status_ch, lvds_status_multi).
package lvds_status_pkg;

   localparam int N_CH_DEF          = 4;
   localparam int CNT_W_DEF         = 8;
   localparam int MIN_HALF_DEF      = 44;
   localparam int MAX_HALF_DEF      = 56;
   localparam int WATCHDOG_TIME_DEF = 150;
   localparam int GOOD_CNT_DEF      = 4;

   // Storage widths of the state record. The counters saturate at bounds derived
   // from CNT_W / GOOD_CNT, so the upper bits stay zero and are trimmed away.
   localparam int ST_CNT_W  = 16;
   localparam int ST_GOOD_W = 8;

   typedef struct packed {
      logic                 seen_edge;  // an edge has been seen since reset / expiry
      logic                 dead;       // watchdog expired, waiting for an edge
      logic [ST_GOOD_W-1:0] good;       // consecutive legal half-periods
      logic [ST_CNT_W-1:0]  hp;         // cycles since the last edge
      logic [ST_CNT_W-1:0]  wd;         // watchdog count since the last edge
   } ch_state_t;

   localparam ch_state_t CH_STATE_RST = '0;

   // A measured half-period is legal when it lies inside [lo..hi], both inclusive.
   function automatic logic half_legal(input logic [ST_CNT_W-1:0] w,
                                       input logic [ST_CNT_W-1:0] lo,
                                       input logic [ST_CNT_W-1:0] hi);
      return (w >= lo) && (w <= hi);
   endfunction

endpackage

// File: rtl/lvds_status_ch.sv
// lvds_status_ch: one monitored LVDS clock. Synchronises the asynchronous pin,
// measures every half-period, watchdogs the channel and registers a qualified flag.
module lvds_status_ch
   import lvds_status_pkg::*;
#(
   parameter int CNT_W         = CNT_W_DEF,
   parameter int MIN_HALF      = MIN_HALF_DEF,
   parameter int MAX_HALF      = MAX_HALF_DEF,
   parameter int WATCHDOG_TIME = WATCHDOG_TIME_DEF,
   parameter int GOOD_CNT      = GOOD_CNT_DEF
) (
   input  logic clk_fpga,
   input  logic rst,
   input  logic clk_in,
   output logic ch_status
);

   // hp saturates at the top of a CNT_W-bit counter even though it is stored wider.
   localparam logic [ST_CNT_W-1:0]  HP_MAX   = ST_CNT_W'((1 << CNT_W) - 1);
   localparam logic [ST_CNT_W-1:0]  MIN_C    = ST_CNT_W'(MIN_HALF);
   localparam logic [ST_CNT_W-1:0]  MAX_C    = ST_CNT_W'(MAX_HALF);
   localparam logic [ST_CNT_W-1:0]  WD_LIM   = ST_CNT_W'(WATCHDOG_TIME);
   localparam logic [ST_GOOD_W-1:0] GOOD_LIM = ST_GOOD_W'(GOOD_CNT);

   logic      s_meta_q, s_meta_d;
   logic      s_sync_q, s_sync_d;
   logic      s_prev_q, s_prev_d;
   ch_state_t st_q, st_d;
   logic      ch_status_q, ch_status_d;
   logic      edge_det;
   logic [ST_CNT_W-1:0] wd_inc;

   // Three-flop chain: two stages of metastability filtering plus the previous level.
   always_comb begin
      s_meta_d = clk_in;
      s_sync_d = s_meta_q;
      s_prev_d = s_sync_q;
      edge_det = s_sync_q ^ s_prev_q;
   end

   // Half-period measurement, qualification counting and watchdog; an edge always
   // takes priority over a watchdog expiry in the same cycle.
   always_comb begin
      st_d   = st_q;
      wd_inc = st_q.wd + ST_CNT_W'(1);
      if (edge_det) begin
         st_d.hp   = ST_CNT_W'(1);
         st_d.wd   = '0;
         st_d.dead = 1'b0;
         if (!st_q.seen_edge) begin
            // First edge after reset or expiry only arms the measurement.
            st_d.seen_edge = 1'b1;
         end else if (half_legal(st_q.hp, MIN_C, MAX_C)) begin
            if (st_q.good != GOOD_LIM) begin
               st_d.good = st_q.good + ST_GOOD_W'(1);
            end
         end else begin
            st_d.good = '0;
         end
      end else begin
         if (st_q.hp != HP_MAX) begin
            st_d.hp = st_q.hp + ST_CNT_W'(1);
         end
         if (st_q.wd != WD_LIM) begin
            st_d.wd = wd_inc;
            if (wd_inc == WD_LIM) begin
               st_d.dead      = 1'b1;
               st_d.seen_edge = 1'b0;
               st_d.good      = '0;
            end
         end
      end
   end

   // The qualified flag follows the registered state one cycle later.
   always_comb begin
      ch_status_d = (st_q.good == GOOD_LIM) && !st_q.dead;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_fpga) begin
      if (rst) begin
         s_meta_q    <= 1'b0;
         s_sync_q    <= 1'b0;
         s_prev_q    <= 1'b0;
         st_q        <= CH_STATE_RST;
         ch_status_q <= 1'b0;
      end else begin
         s_meta_q    <= s_meta_d;
         s_sync_q    <= s_sync_d;
         s_prev_q    <= s_prev_d;
         st_q        <= st_d;
         ch_status_q <= ch_status_d;
      end
   end

   assign ch_status = ch_status_q;

endmodule

// File: rtl/lvds_status_multi.sv
// lvds_status_multi: N_CH-channel LVDS clock-health monitor. One lvds_status_ch per
// channel, a registered AND of all qualified flags, and an optional sticky fault
// register enabled by defining LVDS_STATUS_STICKY_EN.
module lvds_status_multi
   import lvds_status_pkg::*;
#(
   parameter int N_CH          = N_CH_DEF,
   parameter int CNT_W         = CNT_W_DEF,
   parameter int MIN_HALF      = MIN_HALF_DEF,
   parameter int MAX_HALF      = MAX_HALF_DEF,
   parameter int WATCHDOG_TIME = WATCHDOG_TIME_DEF,
   parameter int GOOD_CNT      = GOOD_CNT_DEF
) (
   input  logic            clk_fpga,
   input  logic            rst,
   input  logic [N_CH-1:0] clk_in,
`ifdef LVDS_STATUS_STICKY_EN
   input  logic [N_CH-1:0] fault_clr,
   output logic [N_CH-1:0] fault_sticky,
`endif
   output logic [N_CH-1:0] ch_status,
   output logic            status
);

   // Parameter sanity: the window must fit below the watchdog, which must fit in
   // the counter, and everything must fit in the state record.
   if (N_CH < 1 || N_CH > 16) begin : g_chk_nch
      $error("lvds_status_multi: N_CH must be 1..16");
   end
   if (CNT_W < 1 || CNT_W > ST_CNT_W) begin : g_chk_cntw
      $error("lvds_status_multi: CNT_W out of range");
   end
   if (!(MIN_HALF <= MAX_HALF && MAX_HALF < WATCHDOG_TIME &&
         WATCHDOG_TIME < (1 << CNT_W))) begin : g_chk_window
      $error("lvds_status_multi: need MIN_HALF <= MAX_HALF < WATCHDOG_TIME < 2^CNT_W");
   end
   if (GOOD_CNT < 1 || GOOD_CNT >= (1 << ST_GOOD_W)) begin : g_chk_good
      $error("lvds_status_multi: GOOD_CNT out of range");
   end

   logic [N_CH-1:0] ch_status_w;
   logic            status_q, status_d;

   genvar gi;
   for (gi = 0; gi < N_CH; gi = gi + 1) begin : g_ch
      lvds_status_ch #(
         .CNT_W         (CNT_W),
         .MIN_HALF      (MIN_HALF),
         .MAX_HALF      (MAX_HALF),
         .WATCHDOG_TIME (WATCHDOG_TIME),
         .GOOD_CNT      (GOOD_CNT)
      ) u_ch (
         .clk_fpga  (clk_fpga),
         .rst       (rst),
         .clk_in    (clk_in[gi]),
         .ch_status (ch_status_w[gi])
      );
   end

   // Global health is good only when every channel is qualified.
   always_comb begin
      status_d = &ch_status_w;
   end

   // Global status register.
   always_ff @(posedge clk_fpga) begin
      if (rst) begin
         status_q <= 1'b0;
      end else begin
         status_q <= status_d;
      end
   end

   assign ch_status = ch_status_w;
   assign status    = status_q;

`ifdef LVDS_STATUS_STICKY_EN
   logic [N_CH-1:0] ch_prev_q, ch_prev_d;
   logic [N_CH-1:0] fault_sticky_q, fault_sticky_d;

   // Latch a fault on every 1->0 fall of a channel flag; a new fall beats a clear.
   always_comb begin
      ch_prev_d      = ch_status_w;
      fault_sticky_d = (ch_prev_q & ~ch_status_w) | (fault_sticky_q & ~fault_clr);
   end

   // Sticky fault registers; reset is not treated as a fault.
   always_ff @(posedge clk_fpga) begin
      if (rst) begin
         ch_prev_q      <= '0;
         fault_sticky_q <= '0;
      end else begin
         ch_prev_q      <= ch_prev_d;
         fault_sticky_q <= fault_sticky_d;
      end
   end

   assign fault_sticky = fault_sticky_q;
`endif

endmodule

// File: tb/tb_lvds_status_multi.sv
// tb_lvds_status_multi: randomized clock waveforms per channel, a time-based
// reference model of the monitor rules, and a change-driven scoreboard.
`timescale 1ns/1ps
module tb_lvds_status_multi;

   localparam int N    = 4;
   localparam int MINH = 44;
   localparam int MAXH = 56;
   localparam int WDT  = 150;
   localparam int GC   = 4;
`ifdef LVDS_STATUS_STICKY_EN
   localparam int OW = 2 * N + 1;
`else
   localparam int OW = N + 1;
`endif

   logic         clk_fpga = 1'b0;
   logic         rst;
   logic [N-1:0] clk_in;
   logic [N-1:0] ch_status;
   logic         status;
`ifdef LVDS_STATUS_STICKY_EN
   logic [N-1:0] fault_clr;
   logic [N-1:0] fault_sticky;
   logic [N-1:0] clr_force;
`endif

   always #5 clk_fpga = ~clk_fpga;

   lvds_status_multi #(
      .N_CH          (N),
      .CNT_W         (8),
      .MIN_HALF      (MINH),
      .MAX_HALF      (MAXH),
      .WATCHDOG_TIME (WDT),
      .GOOD_CNT      (GC)
   ) dut (
      .clk_fpga     (clk_fpga),
      .rst          (rst),
      .clk_in       (clk_in),
`ifdef LVDS_STATUS_STICKY_EN
      .fault_clr    (fault_clr),
      .fault_sticky (fault_sticky),
`endif
      .ch_status    (ch_status),
      .status       (status)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      int            cyc;
      logic [OW-1:0] val;
   } exp_t;
   exp_t exp_q[$];

   // ---------------- reference model ----------------
   // Per channel: armed flag, count of consecutive legal halves, dead flag and the
   // clock index at which the last recognised edge (or reset) took effect.
   bit           m_seen [N];
   int           m_good [N];
   bit           m_dead [N];
   int           m_last [N];
   logic [N-1:0] v_h1, v_h2, v_h3;   // pin level as seen by the design, 1..3 clocks ago
   bit           r_h1, r_h2;         // reset 1..2 clocks ago
   logic [N-1:0] ch_h1;              // expected ch_status one clock ago
   logic [OW-1:0] last_exp;
`ifdef LVDS_STATUS_STICKY_EN
   logic [N-1:0] ch_h2;
   logic [N-1:0] stk_h1;
`endif

   int drv_cyc;

   task automatic model_step(input logic r, input logic [N-1:0] pins_u);
      logic [N-1:0]  v_u;
      logic [N-1:0]  ch_u;
      logic          st_u;
      logic [OW-1:0] e;
      int            w;
`ifdef LVDS_STATUS_STICKY_EN
      logic [N-1:0]  stk_u;
      stk_u = r ? '0 : ((~ch_h1 & ch_h2 & {N{!r_h1}}) | (stk_h1 & ~fault_clr));
`endif
      v_u  = r ? '0 : pins_u;
      st_u = !r && (&ch_h1);
      for (int i = 0; i < N; i++) begin
         ch_u[i] = !r && (m_good[i] == GC) && !m_dead[i];
      end
      for (int i = 0; i < N; i++) begin
         if (r) begin
            m_seen[i] = 0; m_good[i] = 0; m_dead[i] = 0; m_last[i] = drv_cyc;
         end else if ((v_h2[i] != v_h3[i]) && !r_h1 && !r_h2) begin
            w = drv_cyc - m_last[i];
            if (!m_seen[i]) m_seen[i] = 1;
            else if (w >= MINH && w <= MAXH) begin
               if (m_good[i] < GC) m_good[i]++;
            end else m_good[i] = 0;
            m_dead[i] = 0;
            m_last[i] = drv_cyc;
         end else if (!m_dead[i] && (drv_cyc - m_last[i] >= WDT)) begin
            m_dead[i] = 1; m_seen[i] = 0; m_good[i] = 0;
         end
      end
      v_h3 = v_h2; v_h2 = v_h1; v_h1 = v_u;
      r_h2 = r_h1; r_h1 = r;
`ifdef LVDS_STATUS_STICKY_EN
      ch_h2  = ch_h1;
      stk_h1 = stk_u;
      e = {stk_u, st_u, ch_u};
`else
      e = {st_u, ch_u};
`endif
      ch_h1 = ch_u;
      if (e !== last_exp) begin
         exp_q.push_back('{drv_cyc, e});
         last_exp = e;
      end
   endtask

   // ---------------- stimulus ----------------
   logic [N-1:0] pins;
   int           cnt  [N];
   bit           hold [N];
   int           wq   [N][$];
   logic         rst_req;

   // Inputs for the next rising edge: advance each channel waveform, then the model.
   task automatic apply();
      int k;
      drv_cyc++;
      for (int i = 0; i < N; i++) begin
         if (!hold[i]) begin
            cnt[i]--;
            if (cnt[i] <= 0) begin
               pins[i] = ~pins[i];
               if (wq[i].size() > 0) cnt[i] = wq[i].pop_front();
               else cnt[i] = int'($urandom_range(MAXH, MINH));
            end
         end
      end
      if (rst_req) begin
         pins = '0;
         for (int i = 0; i < N; i++) cnt[i] = int'($urandom_range(56, 5));
      end
      rst    = rst_req;
      clk_in = pins;
`ifdef LVDS_STATUS_STICKY_EN
      fault_clr = clr_force;
      if ($urandom_range(0, 149) == 0) begin
         k = int'($urandom_range(0, N - 1));
         fault_clr[k] = 1'b1;
      end
`else
      k = 0;
`endif
      model_step(rst_req, pins);
   endtask

   task automatic cycle();
      @(negedge clk_fpga);
      apply();
   endtask

   // ---------------- monitor ----------------
   logic [OW-1:0] obs;
   logic [OW-1:0] last_obs = '0;
   int            mon_cyc  = 0;
   logic          rst_s;
   exp_t          e_pop;

   initial begin
      forever begin
         @(posedge clk_fpga);
         mon_cyc++;
         rst_s = rst;
         #1;
`ifdef LVDS_STATUS_STICKY_EN
         obs = {fault_sticky, status, ch_status};
`else
         obs = {status, ch_status};
`endif
         if (rst_s) begin
            total++;
            if (obs !== '0) begin
               bad++;
               $display("FAIL reset_out cyc=%0d got=%h want=0", mon_cyc, obs);
            end
         end
         if (obs !== last_obs) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_change cyc=%0d got=%h want=%h (no change due)",
                        mon_cyc, obs, last_obs);
            end else begin
               e_pop = exp_q.pop_front();
               if (e_pop.cyc != mon_cyc || e_pop.val !== obs) begin
                  bad++;
                  $display("FAIL out_change got cyc=%0d val=%h want cyc=%0d val=%h",
                           mon_cyc, obs, e_pop.cyc, e_pop.val);
               end else begin
                  $display("change cyc=%0d out=%h ok", mon_cyc, obs);
               end
            end
            last_obs = obs;
         end
      end
   end

   // ---------------- test sequence ----------------
   initial begin
      drv_cyc  = 0;
      pins     = '0;
      v_h1 = '0; v_h2 = '0; v_h3 = '0;
      r_h1 = 0; r_h2 = 0;
      ch_h1    = '0;
      last_exp = '0;
`ifdef LVDS_STATUS_STICKY_EN
      ch_h2     = '0;
      stk_h1    = '0;
      clr_force = '0;
`endif
      for (int i = 0; i < N; i++) begin
         m_seen[i] = 0; m_good[i] = 0; m_dead[i] = 0; m_last[i] = 0;
         hold[i] = 0;
         cnt[i]  = int'($urandom_range(56, 1));
      end

      rst_req = 1'b1;
      apply();
      repeat (2) cycle();
      rst_req = 1'b0;

      // Legal random half-periods everywhere: all channels qualify.
      repeat (1500) cycle();

      // 40/60 duty on ch0 never qualifies.
      for (int k = 0; k < 8; k++) begin
         wq[0].push_back(40);
         wq[0].push_back(60);
      end
      repeat (1200) cycle();

      // Boundary widths on ch1: 44/56 accepted, 43 and 57 rejected.
      wq[1].push_back(44); wq[1].push_back(56); wq[1].push_back(44); wq[1].push_back(56);
      wq[1].push_back(43);
      for (int k = 0; k < 5; k++) wq[1].push_back(int'($urandom_range(MAXH, MINH)));
      wq[1].push_back(44); wq[1].push_back(56); wq[1].push_back(44); wq[1].push_back(56);
      wq[1].push_back(57);
      repeat (1200) cycle();

      // Stall ch3 past the watchdog, then restart it.
      hold[3] = 1;
      repeat (300) cycle();
      hold[3] = 0;
      repeat (600) cycle();

      // One-cycle reset while qualified.
      rst_req = 1'b1;
      cycle();
      rst_req = 1'b0;
      repeat (900) cycle();

`ifdef LVDS_STATUS_STICKY_EN
      // Drop ch2, then clear its sticky flag.
      hold[2] = 1;
      repeat (200) cycle();
      clr_force[2] = 1'b1;
      cycle();
      clr_force = '0;
      hold[2] = 0;
      repeat (700) cycle();
      // Drop ch2 again with a clear landing in the very cycle the fault sets.
      hold[2] = 1;
      for (int k = 0; k < 250; k++) begin
         clr_force[2] = ~ch_h1[2] & ch_h2[2] & ~r_h1;
         cycle();
      end
      clr_force = '0;
      repeat (20) cycle();
      clr_force[2] = 1'b1;
      cycle();
      clr_force = '0;
      hold[2] = 0;
      repeat (700) cycle();
`endif

      repeat (5) cycle();
      @(posedge clk_fpga);
      #3;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL missing_changes got pending=%0d want pending=0 (first due cyc=%0d)",
                  exp_q.size(), exp_q[0].cyc);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
